block_result_drain: RTL
=======================

# block_result_drain

Result-side companion of the 32x4 systolic block in the block-based matrix multiplier. The block snapshots the 32 packed row outputs of a finished tile on a capture strobe and streams them out one row per beat over a valid/ready interface to the tile writer. It turns the wide parallel row bus into a back-pressurable stream, so the array can start the next tile while results drain.

## Interface
- BIT_WIDTH, 16, width of one fixed-point element
- FRAC_WIDTH, 8, fractional bits; carried through only, no arithmetic applied
- ROWS, 32, rows per tile; each row holds 4 elements
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset; one clock, synchronous, active-low
- capture  in  1  single-cycle strobe; rows_in holds a complete tile
- rows_in  in  ROWS*4*BIT_WIDTH  flat row bus; row i occupies bits [(i+1)*4*BIT_WIDTH-1 : i*4*BIT_WIDTH]
- out_data  out  4*BIT_WIDTH  current row, element 0 in the LSBs
- out_valid  out  1  out_data is valid
- out_ready  in  1  sink accepts the beat
- out_row  out  $clog2(ROWS)  index of the current row
- out_last  out  1  high with out_valid on row ROWS-1
- busy  out  1  high while in DRAIN
- overrun  out  1  sticky flag: a capture was dropped
- clr_overrun  in  1  clears overrun

## Operation
- Main buffer: ROWS x 4*BIT_WIDTH registers. Row counter idx. Two states, IDLE and DRAIN.
- IDLE: out_valid=0, busy=0. When capture=1, latch all of rows_in into the main buffer, set idx=0, go to DRAIN.
- DRAIN: out_valid=1, out_data=buf[idx], out_row=idx, out_last=(idx==ROWS-1).
- A beat completes when out_valid&&out_ready. On a completed beat, idx increments. A completed beat at idx==ROWS-1 ends the tile.
- End of tile with no pending tile: go to IDLE and set idx=0.
- While out_valid&&!out_ready, out_data, out_row and out_last stay stable.
- Capture in DRAIN, without the configured feature: the tile is dropped, the buffer is unchanged, and overrun is set. This also applies on the final-beat cycle.
- overrun: set has priority over clr_overrun in the same cycle. Only rst_n or clr_overrun clears it.
- Data is copied bit-exact; no rounding or sign handling.

## Timing
- Reset values: out_valid=0, out_data=0, out_row=0, out_last=0, busy=0, overrun=0. State is IDLE and the shadow buffer is empty.
- Reset mid-drain aborts the tile; out_valid is 0 on the cycle after the reset edge.
- Latency: capture sampled at edge k gives out_valid=1 with row 0 after edge k. Minimum is 1 cycle.
- With out_ready held at 1, a tile drains in ROWS consecutive cycles.
- With no pending tile, at least one IDLE cycle follows the last beat.
- All outputs are registered or decoded from registers only. There is no combinational path from out_ready or capture to any output.

## Configuration
- Macro: BLOCK_RESULT_DRAIN_DOUBLE_BUF_EN.
- Defined: adds a ROWS-deep shadow buffer with a shadow_full flag.
  - Capture in DRAIN with shadow empty: latch into the shadow and set shadow_full.
  - Capture in DRAIN with shadow full: drop it and set overrun.
  - Capture on the final-beat cycle with shadow empty: load directly into the main buffer and stay in DRAIN with idx=0.
  - End of tile with shadow full: copy the shadow into the main buffer, clear shadow_full, set idx=0, stay in DRAIN. There is no bubble, so row 0 of the next tile is presented on the next cycle.
- Undefined: no shadow logic. Any capture in DRAIN is an overrun.

## Test plan
- Reset, then one capture with rows_in row i = {4{16'(i*256)}} (value i.0) and out_ready=1 -> 32 beats on consecutive cycles; beat i has out_data = {4{i*16'h0100}}, out_row=i; out_last only on beat 31; busy drops after beat 31.
- Same tile with out_ready toggled 1,0,0,1 repeating -> out_data and out_row are stable on stall cycles; no row is skipped or repeated; 32 beats in total.
- Macro undefined: second capture (all elements 16'h7FFF) at beat 10 -> overrun=1 from the next cycle; all 32 beats carry the first tile; clr_overrun then clears overrun.
- Macro defined, same stimulus -> no overrun; 64 back-to-back beats, beats 32-63 equal 16'h7FFF; no IDLE cycle between tiles.
- Macro defined: third capture while the shadow is full -> overrun=1 and the third tile is never emitted; a capture coinciding with the beat-31 handshake and shadow empty -> the next cycle shows the new row 0.
- rst_n=0 for one cycle during beat 17 -> out_valid=0 and busy=0 the next cycle; a new capture then restarts from row 0.

Source files
------------

// File: rtl/block_result_drain_if.sv
// rtl/block_result_drain_if.sv - row result stream between the drain block and the tile writer
interface block_result_drain_if #(
  parameter int BIT_WIDTH = 16,
  parameter int ROWS      = 32
);
  logic [4*BIT_WIDTH-1:0]  out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [$clog2(ROWS)-1:0] out_row;
  logic                    out_last;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready,
    output out_row,
    output out_last
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_row,
    input  out_last
  );
endinterface

// File: rtl/block_result_drain.sv
// rtl/block_result_drain.sv - snapshots a 32x4 result tile and streams it out one row per beat
// Optional double buffering: BLOCK_RESULT_DRAIN_DOUBLE_BUF_EN
module block_result_drain #(
  parameter int BIT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int ROWS       = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        capture,
  input  logic [ROWS*4*BIT_WIDTH-1:0] rows_in,
  block_result_drain_if.master        out_if,
  output logic                        busy,
  output logic                        overrun,
  input  logic                        clr_overrun
);
  localparam int ROW_BITS = 4 * BIT_WIDTH;
  localparam int ROW_W    = $clog2(ROWS);
  localparam logic [ROW_W-1:0] IDX_ONE  = ROW_W'(1);
  localparam logic [ROW_W-1:0] IDX_LAST = ROW_W'(ROWS - 1);

  // Fraction bits only travel with the data; reject nonsensical formats at elaboration.
  if (FRAC_WIDTH > BIT_WIDTH) begin : g_bad_frac
    $error("FRAC_WIDTH exceeds BIT_WIDTH");
  end

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    idx_q, idx_d;
  logic                overrun_q, overrun_d;
  logic [ROW_BITS-1:0] buf_q [ROWS];
  logic [ROW_BITS-1:0] buf_d [ROWS];
  logic [ROW_BITS-1:0] row_in [ROWS];
  logic                beat, last_beat, drop;

`ifdef BLOCK_RESULT_DRAIN_DOUBLE_BUF_EN
  logic [ROW_BITS-1:0] shadow_q [ROWS];
  logic [ROW_BITS-1:0] shadow_d [ROWS];
  logic                shadow_full_q, shadow_full_d;
`endif

  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      row_in[i] = rows_in[i*ROW_BITS +: ROW_BITS];
    end
  end

  assign beat      = (state_q == DRAIN) && out_if.out_ready;
  assign last_beat = beat && (idx_q == IDX_LAST);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    overrun_d = overrun_q;
    drop      = 1'b0;
`ifdef BLOCK_RESULT_DRAIN_DOUBLE_BUF_EN
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
`endif
    case (state_q)
      IDLE: begin
        if (capture) begin
          buf_d   = row_in;
          idx_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (beat) idx_d = idx_q + IDX_ONE;
`ifdef BLOCK_RESULT_DRAIN_DOUBLE_BUF_EN
        // A full shadow blocks captures even on the cycle it is promoted.
        drop = capture && shadow_full_q;
        if (last_beat) begin
          idx_d = '0;
          if (shadow_full_q) begin
            buf_d         = shadow_q;
            shadow_full_d = 1'b0;
          end else if (capture) begin
            buf_d = row_in;
          end else begin
            state_d = IDLE;
          end
        end else if (capture && !shadow_full_q) begin
          shadow_d      = row_in;
          shadow_full_d = 1'b1;
        end
`else
        drop = capture;
        if (last_beat) begin
          idx_d   = '0;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (drop) overrun_d = 1'b1;
    else if (clr_overrun) overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
`ifdef BLOCK_RESULT_DRAIN_DOUBLE_BUF_EN
      shadow_full_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
`ifdef BLOCK_RESULT_DRAIN_DOUBLE_BUF_EN
      shadow_full_q <= shadow_full_d;
`endif
    end
  end

  // Row storage needs no reset: its contents are only visible while draining.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
`ifdef BLOCK_RESULT_DRAIN_DOUBLE_BUF_EN
    shadow_q <= shadow_d;
`endif
  end

  assign out_if.out_valid = (state_q == DRAIN);
  assign out_if.out_data  = (state_q == DRAIN) ? buf_q[idx_q] : '0;
  assign out_if.out_row   = idx_q;
  assign out_if.out_last  = (state_q == DRAIN) && (idx_q == IDX_LAST);
  assign busy             = (state_q == DRAIN);
  assign overrun          = overrun_q;
endmodule
